// File: rtl/seq_right_shifter.sv
// Purpose : iterative right shifter (SRL/SRA/SRLV/SRAV, byte-to-word index) under a start/busy/done handshake.
// Latency : done pulses shamt+1 cycles after the accepting edge; with SHIFT_STEP4_EN, floor(shamt/4)+shamt%4+1.
// Backpressure: start is sampled only when idle; a start while busy is dropped, never queued.
module seq_right_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] count_nxt;
    logic               fill;
    logic               fill_nxt;
    logic [WIDTH-1:0]   out_nxt;

    // Next-state and datapath: capture operands when idle, then peel off bits until count runs out.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        fill_nxt  = fill;
        out_nxt   = out;
        case (state)
            IDLE: begin
                if (start) begin
                    out_nxt   = in;
                    count_nxt = shamt;
                    // Fill bit is frozen from the operand's MSB, not from the shifting register.
                    fill_nxt  = arith & in[WIDTH-1];
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
`ifdef SHIFT_STEP4_EN
                if (count >= SHAMT_W'(4)) begin
                    out_nxt   = {{4{fill}}, out[WIDTH-1:4]};
                    count_nxt = count - SHAMT_W'(4);
                    if (count == SHAMT_W'(4)) begin
                        state_nxt = DONE;
                    end
                end else begin
                    out_nxt   = {fill, out[WIDTH-1:1]};
                    count_nxt = count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        state_nxt = DONE;
                    end
                end
`else
                out_nxt   = {fill, out[WIDTH-1:1]};
                count_nxt = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight shift immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            fill  <= 1'b0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            fill  <= fill_nxt;
            out   <= out_nxt;
        end
    end

    // Status flags are registered decodes of the next state, so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Bench for seq_right_shifter: directed cases with literal results and latencies, then random
// traffic (including starts while busy and occasional resets) checked every cycle by a model.
module tb_seq_right_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

`ifdef SHIFT_STEP4_EN
    localparam int LAT_S4  = 2;
    localparam int LAT_S31 = 11;
    localparam int LAT_S8  = 3;
`else
    localparam int LAT_S4  = 5;
    localparam int LAT_S31 = 32;
    localparam int LAT_S8  = 9;
`endif

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   in_d;
    logic [SHAMT_W-1:0] shamt_d;
    logic               arith_d;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    seq_right_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in_d),
        .shamt (shamt_d),
        .arith (arith_d),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result: a plain shift of the operand, all fill bits once the shift covers the word.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] v, input int sh, input logic ar);
        logic fillb;
        fillb = ar & v[WIDTH-1];
        if (sh >= WIDTH) return {WIDTH{fillb}};
        if (ar) return WIDTH'($signed(v) >>> sh);
        return v >> sh;
    endfunction

    // Number of cycles spent shifting for a given amount.
    function automatic int shift_cycles(input int sh);
`ifdef SHIFT_STEP4_EN
        return sh / 4 + sh % 4;
`else
        return sh;
`endif
    endfunction

    // Model: an operation is an interval of cycles [accept+1 .. done_at]; result is known at accept.
    logic             m_active  = 1'b0;
    int               m_done_at = 0;
    logic [WIDTH-1:0] m_out     = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_out", out, 32'd0);
            m_active = 1'b0;
            m_out    = '0;
        end else begin
            chk("m_busy", {31'd0, busy}, {31'd0, m_active});
            chk("m_done", {31'd0, done}, {31'd0, (m_active && cyc == m_done_at)});
            if (!m_active || cyc == m_done_at) begin
                chk("m_out", out, m_out);
            end
            if (m_active) begin
                if (cyc == m_done_at) m_active = 1'b0;
            end else if (start) begin
                m_active  = 1'b1;
                m_done_at = cyc + 1 + shift_cycles(int'(shamt_d));
                m_out     = ref_shift(in_d, int'(shamt_d), arith_d);
            end
        end
    end

    // Pulses start, optionally re-pulses start with other operands while busy, and measures latency.
    task automatic run_op(input string name, input logic [WIDTH-1:0] v, input int sh, input logic ar,
                          input logic [WIDTH-1:0] exp_out, input int exp_lat, input bit poke);
        int k;
        bit seen;
        @(posedge clk);
        #2;
        in_d = v; shamt_d = SHAMT_W'(sh); arith_d = ar; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #2;
                in_d = $urandom; shamt_d = SHAMT_W'($urandom); arith_d = 1'($urandom);
                if (poke && k == 2) begin
                    in_d = 32'hFFFF_FFFF; shamt_d = 5'd1; arith_d = 1'b0; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected latency %0d", name, k, exp_lat);
        end else begin
            chk({name, "_lat"}, k, exp_lat);
            chk({name, "_out"}, out, exp_out);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_d = '0; shamt_d = '0; arith_d = 1'b0;
        @(negedge clk);
        chk("reset_out", out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_op("srl4",   32'h8000_0000, 4,  1'b0, 32'h0800_0000, LAT_S4,  1'b0);
        run_op("sra4",   32'h8000_0000, 4,  1'b1, 32'hF800_0000, LAT_S4,  1'b0);
        run_op("sh0",    32'h1234_5678, 0,  1'b0, 32'h1234_5678, 1,       1'b0);
        run_op("sra31",  32'h8000_0001, 31, 1'b1, 32'hFFFF_FFFF, LAT_S31, 1'b0);
        run_op("srl31",  32'h8000_0001, 31, 1'b0, 32'h0000_0001, LAT_S31, 1'b0);
        run_op("ignore", 32'h0000_FF00, 8,  1'b0, 32'h0000_00FF, LAT_S8,  1'b1);

        // The dropped request must not produce a second done.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_second_done", {31'd0, done}, 32'd0);
        end
        chk("held_out", out, 32'h0000_00FF);

        // Abort a long shift with an asynchronous reset between edges.
        @(posedge clk);
        #2;
        in_d = 32'hDEAD_BEEF; shamt_d = 5'd10; arith_d = 1'b1; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_out", out, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op("after_rst", 32'h0000_0010, 2, 1'b0, 32'h0000_0004, 3, 1'b0);

        // Random traffic: start asserted freely, including while busy, with rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            in_d    = $urandom;
            shamt_d = SHAMT_W'($urandom);
            arith_d = 1'($urandom);
            start   = ($urandom_range(0, 3) == 0);
            rst_n   = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1; start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
